// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash read arbiter.
// Holds state encoding, SPI command bytes, bit counts and requester ids.
package flash_arb_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DESELECT
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;

  localparam logic [5:0] CMD_BITS   = 6'd8;
  localparam logic [5:0] ADDR_BITS  = 6'd24;
  localparam logic [5:0] DUMMY_BITS = 6'd8;
  localparam logic [5:0] DATA_BITS  = 6'd8;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_TEXT = 1'b1;

  // A length field of zero encodes a full 64-byte burst.
  function automatic logic [6:0] burst_bytes(input logic [5:0] len);
    return (len == 6'd0) ? 7'd64 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit-cell shifter: 2 clk per bit, MSB-first, up to 32 bits per load.
// done is high during the last sample cycle so the next segment can start seamlessly.
module spi_shift_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] load,
  input  logic [5:0]  bits,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [7:0]  rx_byte
);

  logic        active;
  logic        phase;
  logic [5:0]  bits_left;
  logic [31:0] tx_sr;
  logic [6:0]  rx_sr;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      active    <= 1'b0;
      phase     <= 1'b0;
      bits_left <= 6'd0;
      tx_sr     <= 32'd0;
      rx_sr     <= 7'd0;
    end else if (start) begin
      active    <= 1'b1;
      phase     <= 1'b0;
      bits_left <= bits;
      tx_sr     <= load;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
      end else begin
        phase     <= 1'b0;
        tx_sr     <= {tx_sr[30:0], 1'b0};
        rx_sr     <= {rx_sr[5:0], miso};
        bits_left <= bits_left - 6'd1;
        if (bits_left == 6'd1) active <= 1'b0;
      end
    end
  end

  assign sck  = active & phase;
  assign mosi = active & tx_sr[31];
  assign done = active & phase & (bits_left == 6'd1);
  // Final bit is taken straight from the pin so the byte is usable on its sample edge.
  assign rx_byte = {rx_sr, miso};

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one SPI flash between CPU fetch (port 0) and text fetch (port 1).
// Define FLASH_ARB_FAST_READ_EN to use command 0x0B with one dummy byte after the address.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int STARTUP_WAIT   = 10000000,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [5:0]  len0,
  input  logic [5:0]  len1,
  output logic [1:0]  ack,
  output logic [7:0]  rd_data,
  output logic [1:0]  rd_valid,
  output logic [1:0]  done,
  output logic        busy,
  output logic        flash_clk,
  output logic        flash_cs,
  output logic        flash_MOSI,
  input  logic        flash_MISO
);

`ifdef FLASH_ARB_FAST_READ_EN
  localparam logic [7:0] READ_CMD  = CMD_FAST_READ;
  localparam logic       HAS_DUMMY = 1'b1;
`else
  localparam logic [7:0] READ_CMD  = CMD_READ;
  localparam logic       HAS_DUMMY = 1'b0;
`endif

  state_t      state, state_nx;
  logic [31:0] wait_cnt;
  logic [23:0] addr_q;
  logic [6:0]  bytes_left;
  logic        id_q;
  logic        last_grant;
  logic        grant_id;
  logic        last_byte;

  logic        eng_start;
  logic [31:0] eng_load;
  logic [5:0]  eng_bits;
  logic        eng_done;
  logic [7:0]  eng_rx;

  assign last_byte = (bytes_left == 7'd1);

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    grant_id = REQ_CPU;
    if (req == 2'b11)       grant_id = ~last_grant;
    else if (req[REQ_TEXT]) grant_id = REQ_TEXT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT:     if (wait_cnt == 32'(STARTUP_WAIT - 1)) state_nx = ST_IDLE;
      ST_IDLE:     if (req != 2'b00) state_nx = ST_CMD;
      ST_CMD:      if (eng_done) state_nx = ST_ADDR;
      ST_ADDR:     if (eng_done) state_nx = HAS_DUMMY ? ST_DUMMY : ST_DATA;
      ST_DUMMY:    if (eng_done) state_nx = ST_DATA;
      ST_DATA:     if (eng_done && last_byte) state_nx = ST_DESELECT;
      ST_DESELECT: if (wait_cnt == 32'd0) state_nx = ST_IDLE;
      default:     state_nx = ST_INIT;
    endcase
  end

  // Each segment is chained into the engine on the last sample cycle of the previous one.
  always_comb begin
    eng_start = 1'b0;
    eng_load  = 32'd0;
    eng_bits  = DATA_BITS;
    flash_cs  = 1'b1;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          eng_start = 1'b1;
          eng_load  = {READ_CMD, 24'h000000};
          eng_bits  = CMD_BITS;
        end
      end
      ST_CMD: begin
        flash_cs = 1'b0;
        if (eng_done) begin
          eng_start = 1'b1;
          eng_load  = {addr_q, 8'h00};
          eng_bits  = ADDR_BITS;
        end
      end
      ST_ADDR: begin
        flash_cs = 1'b0;
        if (eng_done) begin
          eng_start = 1'b1;
          eng_bits  = HAS_DUMMY ? DUMMY_BITS : DATA_BITS;
        end
      end
      ST_DUMMY: begin
        flash_cs = 1'b0;
        eng_start = eng_done;
      end
      ST_DATA: begin
        flash_cs  = 1'b0;
        eng_start = eng_done && !last_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack        <= 2'b00;
      rd_valid   <= 2'b00;
      done       <= 2'b00;
      rd_data    <= 8'h00;
      addr_q     <= 24'h000000;
      bytes_left <= 7'd0;
      id_q       <= REQ_CPU;
      last_grant <= REQ_TEXT;
      wait_cnt   <= 32'd0;
    end else begin
      ack      <= 2'b00;
      rd_valid <= 2'b00;
      done     <= 2'b00;

      case (state)
        ST_INIT:     wait_cnt <= wait_cnt + 32'd1;
        ST_DESELECT: wait_cnt <= wait_cnt - 32'd1;
        default:     wait_cnt <= 32'(CS_HIGH_CYCLES - 1);
      endcase

      if (state == ST_IDLE && req != 2'b00) begin
        ack[grant_id] <= 1'b1;
        id_q          <= grant_id;
        last_grant    <= grant_id;
        addr_q        <= grant_id ? addr1 : addr0;
        bytes_left    <= burst_bytes(grant_id ? len1 : len0);
      end

      if (state == ST_DATA && eng_done) begin
        rd_data        <= eng_rx;
        rd_valid[id_q] <= 1'b1;
        bytes_left     <= bytes_left - 7'd1;
        if (last_byte) done[id_q] <= 1'b1;
      end
    end
  end

  spi_shift_engine u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .load    (eng_load),
    .bits    (eng_bits),
    .miso    (flash_MISO),
    .sck     (flash_clk),
    .mosi    (flash_MOSI),
    .done    (eng_done),
    .rx_byte (eng_rx)
  );

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the on-board SPI flash between two read requesters: port 0 for CPU program/ROM fetch and port 1 for the text engine's character fetch. The block owns the flash pins. After a power-up wait it runs SPI read transactions: command, 24-bit address, then N data bytes. Each granted burst is streamed back byte-by-byte to the requester that owns it.

Parameters:
STARTUP_WAIT, 10000000, clk cycles after reset before the first transaction is allowed
CS_HIGH_CYCLES, 4, minimum cycles flash_cs stays high between transactions (range 1..15)

Ports:
clk  input  1  system clock (27 MHz)
rst  input  1  synchronous, active-high reset
req  input  2  per-requester read request, level; held until ack
addr0  input  24  requester 0 flash byte address
addr1  input  24  requester 1 flash byte address
len0  input  6  requester 0 byte count; 1..63 as given, 0 means 64
len1  input  6  requester 1 byte count; same encoding
ack  output  2  one-cycle grant pulse; addr/len are latched on this cycle
rd_data  output  8  shared data byte, MSB-first as received
rd_valid  output  2  one-hot strobe: rd_data valid for the indicated requester
done  output  2  one-cycle pulse with the last rd_valid of a burst
busy  output  1  high when not in IDLE
flash_clk  output  1  SPI clock, mode 0
flash_cs  output  1  chip select, active low
flash_MOSI  output  1  SPI data to flash
flash_MISO  input  1  SPI data from flash

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - flash_cs=1, flash_clk=0, flash_MOSI=0.
  - ack, rd_valid, done = 0; rd_data=0; busy=1.
  - Round-robin pointer favours requester 0.
  - State = INIT.
- Reset mid-transaction: on the next edge cs=1 and clk=0, the burst is abandoned, and no done pulse is issued. The requester must re-request.
- States: INIT -> IDLE -> CMD -> ADDR -> DATA -> DESELECT -> IDLE.
- INIT: count STARTUP_WAIT cycles, then go to IDLE. Requests are ignored and ack stays 0.
- IDLE:
  - If any req bit is set, grant one requester, pulse its ack, latch addr/len/id, assert flash_cs=0, and go to CMD.
  - Both requesting: grant the requester not granted last. The first conflict after reset goes to 0.
  - A req that drops before ack is simply not served.
- SPI bit cell is 2 clk:
  - Phase 0: flash_clk=0, MOSI drives the next bit.
  - Phase 1: flash_clk=1, MISO is sampled.
  - SCK is therefore clk/2. Bits are shifted MSB-first.
- CMD: shift out 0x03 (8 bits). ADDR: shift out the latched address (24 bits).
- DATA:
  - Each byte takes 16 clk.
  - On the cycle after the 8th sample, rd_data is updated and rd_valid[id] pulses for 1 cycle.
- Latency:
  - First rd_valid comes exactly 80 cycles after the ack cycle.
  - Each following byte comes 16 cycles after the previous one.
- done[id] pulses on the same cycle as the final rd_valid.
- Byte counter is 7 bits so that len=0 runs 64 bytes.
- After the final byte: flash_cs=1 and flash_clk=0, then hold DESELECT for CS_HIGH_CYCLES. The earliest next ack is CS_HIGH_CYCLES+1 cycles after done.
- Address is not checked against flash size; the flash's internal address wrap applies.
- A requester re-asserting req during its own burst waits; fairness still alternates.

Optional Feature:
FLASH_ARB_FAST_READ_EN
- Defined: command is 0x0B and one dummy byte (8 bits, MOSI=0) follows the address before DATA. First rd_valid comes 96 cycles after ack.
- Undefined: command is 0x03, no dummy byte, 80-cycle latency.

Decomposition:
- Package flash_arb_pkg holds:
  - State encoding constants.
  - CMD_READ=8'h03, CMD_FAST_READ=8'h0B.
  - Bit counts: CMD=8, ADDR=24, DUMMY=8.
  - Requester id constants REQ_CPU=0, REQ_TEXT=1.
- One sub-module, spi_shift_engine: the 2-clk bit-cell shifter with load/bits/start inputs and done/rx_byte outputs. The arbiter FSM sequences it.

Test Plan:
- STARTUP_WAIT=20; req=2'b01 at cycle 5 -> no ack before cycle 21. Ack[0] then pulses once and busy=1.
- req0, addr0=24'h000100, len0=1; flash model returns 8'hA5 -> MOSI shows 0x03,0x000100; rd_valid[0]=1 with rd_data=8'hA5 80 cycles after ack; done[0] on the same cycle; cs high 4 cycles later.
- req=2'b11 held, len=2 each -> acks alternate 0,1,0,1; rd_valid never asserted for the non-owner; cs high ≥4 cycles between bursts.
- len1=0 -> exactly 64 rd_valid[1] pulses spaced 16 cycles apart, done[1] on the 64th.
- rst=1 during byte 3 of an 8-byte burst -> next edge cs=1, clk=0, no done; after re-init the same request completes with all 8 bytes.
- With FLASH_ARB_FAST_READ_EN: command 0x0B, 8 zero dummy bits, first rd_valid at ack+96.
